// File: rtl/fft4_cplx_engine.sv
// 4-point complex DFT engine, forward or unscaled inverse.
// A single radix-2 butterfly is reused over four cycles per frame.
module fft4_cplx_engine #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_inverse,
  input  logic [4*WIDTH-1:0]        in_re,
  input  logic [4*WIDTH-1:0]        in_im,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [4*(WIDTH+2)-1:0]    out_re,
  output logic [4*(WIDTH+2)-1:0]    out_im,
  output logic                      busy
);

  localparam int W1 = WIDTH + 1;
  localparam int OW = WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BF0  = 3'd1,
    BF1  = 3'd2,
    BF2  = 3'd3,
    BF3  = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [4*WIDTH-1:0] x_re, x_im;
  logic               inv;

  logic [W1-1:0] a0_re, a0_im, a1_re, a1_im;
  logic [W1-1:0] b0_re, b0_im, b1_re, b1_im;
  logic [OW-1:0] y0_re, y0_im, y2_re, y2_im;

  logic signed [OW-1:0] p_re, p_im, q_re, q_im;
  logic signed [OW-1:0] s_re, s_im, d_re, d_im;

  function automatic logic signed [OW-1:0] sx_in(input logic [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [OW-1:0] sx_mid(input logic [W1-1:0] v);
    return {v[W1-1], v};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BF0;
      BF0:     state_nxt = BF1;
      BF1:     state_nxt = BF2;
      BF2:     state_nxt = BF3;
      BF3:     state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand select for the shared butterfly; t = W*b1 is formed at OW bits
  always_comb begin
    p_re = '0;
    p_im = '0;
    q_re = '0;
    q_im = '0;
    case (state)
      BF0: begin
        p_re = sx_in(x_re[0*WIDTH +: WIDTH]);
        p_im = sx_in(x_im[0*WIDTH +: WIDTH]);
        q_re = sx_in(x_re[2*WIDTH +: WIDTH]);
        q_im = sx_in(x_im[2*WIDTH +: WIDTH]);
      end
      BF1: begin
        p_re = sx_in(x_re[1*WIDTH +: WIDTH]);
        p_im = sx_in(x_im[1*WIDTH +: WIDTH]);
        q_re = sx_in(x_re[3*WIDTH +: WIDTH]);
        q_im = sx_in(x_im[3*WIDTH +: WIDTH]);
      end
      BF2: begin
        p_re = sx_mid(a0_re);
        p_im = sx_mid(a0_im);
        q_re = sx_mid(b0_re);
        q_im = sx_mid(b0_im);
      end
      BF3: begin
        p_re = sx_mid(a1_re);
        p_im = sx_mid(a1_im);
        if (inv) begin
          q_re = -sx_mid(b1_im);
          q_im = sx_mid(b1_re);
        end else begin
          q_re = sx_mid(b1_im);
          q_im = -sx_mid(b1_re);
        end
      end
      default: ;
    endcase
  end

  assign s_re = p_re + q_re;
  assign s_im = p_im + q_im;
  assign d_re = p_re - q_re;
  assign d_im = p_im - q_im;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_re   <= '0;
      x_im   <= '0;
      inv    <= 1'b0;
      a0_re  <= '0;
      a0_im  <= '0;
      a1_re  <= '0;
      a1_im  <= '0;
      b0_re  <= '0;
      b0_im  <= '0;
      b1_re  <= '0;
      b1_im  <= '0;
      y0_re  <= '0;
      y0_im  <= '0;
      y2_re  <= '0;
      y2_im  <= '0;
      out_re <= '0;
      out_im <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x_re <= in_re;
          x_im <= in_im;
          inv  <= in_inverse;
        end
        BF0: begin
          a0_re <= s_re[W1-1:0];
          a0_im <= s_im[W1-1:0];
          a1_re <= d_re[W1-1:0];
          a1_im <= d_im[W1-1:0];
        end
        BF1: begin
          b0_re <= s_re[W1-1:0];
          b0_im <= s_im[W1-1:0];
          b1_re <= d_re[W1-1:0];
          b1_im <= d_im[W1-1:0];
        end
        BF2: begin
          y0_re <= s_re;
          y0_im <= s_im;
          y2_re <= d_re;
          y2_im <= d_im;
        end
        BF3: begin
          out_re <= {d_re, y2_re, s_re, y0_re};
          out_im <= {d_im, y2_im, s_im, y0_im};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft4_cplx_engine.sv
// Directed bench for fft4_cplx_engine with hand-computed DFT results.
// Covers reset, latency, both directions, extremes, backpressure, mid-frame reset.
module tb_fft4_cplx_engine;

  localparam int W  = 16;
  localparam int OW = 18;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_inverse = 1'b0;
  logic            out_ready = 1'b0;
  logic [4*W-1:0]  in_re = '0;
  logic [4*W-1:0]  in_im = '0;
  logic            in_ready, out_valid, busy;
  logic [4*OW-1:0] out_re, out_im;

  int n_vec = 0;
  int n_err = 0;

  fft4_cplx_engine #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inverse(in_inverse),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [4*W-1:0] pk(input int v[4]);
    logic [4*W-1:0] r;
    int t;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      t = v[i];
      r[i*W +: W] = t[W-1:0];
    end
    return r;
  endfunction

  function automatic longint bin(input logic [4*OW-1:0] v, input int k);
    logic signed [OW-1:0] t;
    t = v[k*OW +: OW];
    return longint'(t);
  endfunction

  task automatic send(input int xr[4], input int xi[4], input logic dir);
    in_re      = pk(xr);
    in_im      = pk(xi);
    in_inverse = dir;
    in_valid   = 1'b1;
    check("accept.in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_re      = {$urandom, $urandom};
    in_im      = {$urandom, $urandom};
    in_inverse = ~dir;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".latency"}, n, 4);
  endtask

  task automatic check_bins(input string tag, input int er[4], input int ei[4]);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s.re%0d", tag, k), bin(out_re, k), er[k]);
      check($sformatf("%s.im%0d", tag, k), bin(out_im, k), ei[k]);
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drain_valid"}, out_valid, 0);
  endtask

  task automatic frame(input string tag, input int xr[4], input int xi[4],
                       input logic dir, input int er[4], input int ei[4]);
    send(xr, xi, dir);
    wait_out(tag);
    check_bins(tag, er, ei);
    drain(tag);
  endtask

  initial begin
    #2;
    check("rst.out_valid", out_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.in_ready", in_ready, 1);
    check("rst.out_re_zero", out_re == '0, 1);
    check("rst.out_im_zero", out_im == '0, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("rel.in_ready", in_ready, 1);

    frame("imp", '{1, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0,
          '{1, 1, 1, 1}, '{0, 0, 0, 0});
    frame("dc_f", '{100, 100, 100, 100}, '{0, 0, 0, 0}, 1'b0,
          '{400, 0, 0, 0}, '{0, 0, 0, 0});
    frame("dc_i", '{100, 100, 100, 100}, '{0, 0, 0, 0}, 1'b1,
          '{400, 0, 0, 0}, '{0, 0, 0, 0});
    frame("rot_f", '{0, 1, 0, -1}, '{0, 0, 0, 0}, 1'b0,
          '{0, 0, 0, 0}, '{0, -2, 0, 2});
    frame("rot_i", '{0, 1, 0, -1}, '{0, 0, 0, 0}, 1'b1,
          '{0, 0, 0, 0}, '{0, 2, 0, -2});
    frame("ext_all", '{-32768, -32768, -32768, -32768},
          '{32767, 32767, 32767, 32767}, 1'b0,
          '{-131072, 0, 0, 0}, '{131068, 0, 0, 0});
    frame("ext_f", '{32767, 0, -32768, 0}, '{0, -32768, 0, 32767}, 1'b0,
          '{-1, 0, -1, 131070}, '{-1, 0, 1, 0});
    frame("ext_i", '{32767, 0, -32768, 0}, '{0, -32768, 0, 32767}, 1'b1,
          '{-1, 131070, -1, 0}, '{-1, 0, 1, 0});

    // Backpressure with a competing frame held on the input
    send('{1, 3, 5, 7}, '{2, 4, 6, 8}, 1'b0);
    wait_out("bp");
    check_bins("bp", '{16, -8, -4, 0}, '{20, 0, -4, -8});
    in_re      = pk('{100, 100, 100, 100});
    in_im      = '0;
    in_inverse = 1'b0;
    in_valid   = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp.out_valid", out_valid, 1);
      check("bp.in_ready", in_ready, 0);
      check("bp.re1", bin(out_re, 1), -8);
      check("bp.im3", bin(out_im, 3), -8);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp.rel_valid", out_valid, 0);
    check("bp.rel_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.next_busy", busy, 1);
    wait_out("bp_next");
    check_bins("bp_next", '{400, 0, 0, 0}, '{0, 0, 0, 0});
    drain("bp_next");

    // Reset asserted while the butterfly is in BF2
    send('{1, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid.busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid.out_valid", out_valid, 0);
    check("mid.busy_rst", busy, 0);
    check("mid.out_re_zero", out_re == '0, 1);
    check("mid.out_im_zero", out_im == '0, 1);
    #1;
    reset_n = 1'b1;
    check("mid.in_ready", in_ready, 1);
    repeat (6) begin
      @(posedge clk); #1;
      check("mid.no_valid", out_valid, 0);
    end
    frame("imp2", '{1, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0,
          '{1, 1, 1, 1}, '{0, 0, 0, 0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
